// File: rtl/fifo_pkg.sv
//==========================================================================
// Module : fifo_pkg
// Brief  : Shared state encoding and width helper for the FIFO write arbiter.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

package fifo_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // Index width that stays at least one bit wide for a single requester.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
//==========================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first set request above i_ptr.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module rr_pick
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]               i_req,
   input  logic [clog2_min1(NUM_REQ)-1:0]   i_ptr,
   output logic                             o_found,
   output logic [clog2_min1(NUM_REQ)-1:0]   o_idx
);

   localparam int c_iw = clog2_min1(NUM_REQ);

   logic            w_found_hi;
   logic [c_iw-1:0] w_idx_hi;
   logic [c_iw-1:0] w_idx_lo;

   // Descending scan so the lowest qualifying index is the one left standing;
   // with nothing above the pointer the search wraps to the lowest request.
   always_comb begin
      o_found    = 1'b0;
      w_found_hi = 1'b0;
      w_idx_hi   = '0;
      w_idx_lo   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_found  = 1'b1;
            w_idx_lo = c_iw'(i);
            if (i > int'(i_ptr)) begin
               w_found_hi = 1'b1;
               w_idx_hi   = c_iw'(i);
            end
         end
      end
      o_idx = w_found_hi ? w_idx_hi : w_idx_lo;
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
//==========================================================================
// Module : fifo_wr_arbiter
// Brief  : Round-robin, burst-based sharing of one async FIFO write port.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 4,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic                             wr_clk,
   input  logic                             wr_rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ-1:0]               req_last,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             fifo_full,
   output logic                             fifo_wr_en,
   output logic [DATA_WIDTH-1:0]            fifo_wr_data,
   output logic [clog2_min1(NUM_REQ)-1:0]   grant_id,
   output logic                             grant_active
);

   localparam int c_gw = clog2_min1(NUM_REQ);
   localparam int c_bw = $clog2(MAX_BURST + 1);
   localparam int c_iw = $clog2(IDLE_TIMEOUT + 1);

   arb_state_t      r_state,    w_state_nxt;
   logic [c_gw-1:0] r_grant_id, w_grant_nxt;
   logic [c_gw-1:0] r_rr_ptr,   w_rr_nxt;
   logic [c_bw-1:0] r_beat_cnt, w_beat_nxt;
   logic [c_iw-1:0] r_idle_cnt, w_idle_nxt;

   logic            w_pick_found;
   logic [c_gw-1:0] w_pick_idx;
   logic            w_burst;
   logic            w_sel_valid;
   logic            w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic            w_xfer;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == c_gw'(i)) begin
            w_sel_valid = req_valid[i];
            w_sel_last  = req_last[i];
            w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_burst = (r_state == ARB_BURST);
   assign w_xfer  = w_burst & w_sel_valid & ~fifo_full;

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_state    <= ARB_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= c_gw'(NUM_REQ - 1);
         r_beat_cnt <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_id <= w_grant_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_idle_cnt <= w_idle_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant_id;
      w_rr_nxt     = r_rr_ptr;
      w_beat_nxt   = r_beat_cnt;
      w_idle_nxt   = r_idle_cnt;
      req_ready    = '0;
      fifo_wr_en   = w_xfer;
      fifo_wr_data = w_burst ? w_sel_data : '0;
      grant_id     = r_grant_id;
      grant_active = w_burst;

      case (r_state)
         ARB_IDLE: begin
            w_beat_nxt = '0;
            w_idle_nxt = '0;
            if (w_pick_found) begin
               w_grant_nxt = w_pick_idx;
               w_state_nxt = ARB_BURST;
            end
         end
         ARB_BURST: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (r_grant_id == c_gw'(i)) && !fifo_full;
            end
            if (w_xfer) begin
               w_beat_nxt = r_beat_cnt + c_bw'(1);
               w_idle_nxt = '0;
               if (w_sel_last || (r_beat_cnt == c_bw'(MAX_BURST - 1))) begin
                  w_rr_nxt    = r_grant_id;
                  w_state_nxt = ARB_IDLE;
               end
            end else if (!fifo_full) begin
               // Only genuine source idleness counts; full stalls freeze the count.
               if (r_idle_cnt < c_iw'(IDLE_TIMEOUT)) begin
                  w_idle_nxt = r_idle_cnt + c_iw'(1);
               end
               if (r_idle_cnt >= c_iw'(IDLE_TIMEOUT - 1)) begin
                  w_rr_nxt    = r_grant_id;
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//==========================================================================
// Module : tb_fifo_wr_arbiter
// Brief  : Directed self-checking bench for fifo_wr_arbiter (4 requesters).
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

   logic        wr_clk = 1'b0;
   logic        wr_rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic [1:0]  grant_id;
   logic        grant_active;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_wr     = 0;
   int inv_viol = 0;

   logic [8:0] src_mem [4][16];
   int         src_len [4];
   int         src_pos [4];
   int         wr_cyc  [64];
   logic [1:0] wr_gid  [64];
   logic       act_log [64];
   int         mb_cyc  [10] = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13};

   fifo_wr_arbiter #(
      .DATA_WIDTH   (8),
      .NUM_REQ      (4),
      .MAX_BURST    (4),
      .IDLE_TIMEOUT (8)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst       (wr_rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_id     (grant_id),
      .grant_active (grant_active)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic load(input int r, input logic [7:0] d, input logic l);
      src_mem[r][src_len[r]] = {l, d};
      src_len[r]++;
   endtask

   // Drive on the falling edge, sample 2 ns later, well before the rising edge.
   task automatic step(input logic full);
      @(negedge wr_clk);
      cyc++;
      fifo_full = full;
      for (int i = 0; i < 4; i++) begin
         if (src_pos[i] < src_len[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = src_mem[i][src_pos[i]][7:0];
            req_last[i]        = src_mem[i][src_pos[i]][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      #2;
      if (fifo_wr_en && fifo_full) inv_viol++;
      if (cyc < 64) act_log[cyc] = grant_active;
      if (fifo_wr_en) begin
         check("sb_data", {24'h0, fifo_wr_data}, {24'h0, src_mem[grant_id][src_pos[grant_id]][7:0]});
         if (n_wr < 64) begin
            wr_cyc[n_wr] = cyc;
            wr_gid[n_wr] = grant_id;
         end
         n_wr++;
      end
      for (int i = 0; i < 4; i++) begin
         if (req_valid[i] && req_ready[i]) src_pos[i]++;
      end
   endtask

   task automatic do_reset();
      @(negedge wr_clk);
      wr_rst    = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      for (int r = 0; r < 4; r++) begin
         src_len[r] = 0;
         src_pos[r] = 0;
      end
      #1;
      check("rst_outputs", {16'h0, fifo_wr_en, req_ready, grant_active, grant_id, fifo_wr_data}, 32'h0);
      repeat (2) @(negedge wr_clk);
      wr_rst = 1'b0;
      cyc    = 0;
      n_wr   = 0;
   endtask

   initial begin
      #1;
      check("por_outputs", {16'h0, fifo_wr_en, req_ready, grant_active, grant_id, fifo_wr_data}, 32'h0);

      // Round robin: two single-beat packets per requester.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         load(r, 8'(8'hA0 + r), 1'b1);
         load(r, 8'(8'hB0 + r), 1'b1);
      end
      for (int s = 1; s <= 20; s++) step(1'b0);
      check("rr_count", n_wr, 8);
      for (int k = 0; k < 8; k++) begin
         check("rr_cycle", wr_cyc[k], 2 + 2 * k);
         check("rr_gid", {30'h0, wr_gid[k]}, k % 4);
      end

      // Requester 2 streams 10 beats: bursts of 4, 4, 2.
      do_reset();
      for (int k = 1; k <= 10; k++) load(2, 8'(8'h20 + k), (k == 10));
      for (int s = 1; s <= 16; s++) step(1'b0);
      check("mb_count", n_wr, 10);
      for (int k = 0; k < 10; k++) begin
         check("mb_cycle", wr_cyc[k], mb_cyc[k]);
         check("mb_gid", {30'h0, wr_gid[k]}, 2);
      end

      // Full for 5 cycles after beat 1 of a 3-beat packet.
      do_reset();
      load(0, 8'h31, 1'b0);
      load(0, 8'h32, 1'b0);
      load(0, 8'h33, 1'b1);
      for (int s = 1; s <= 12; s++) step(s >= 3 && s <= 7);
      check("full_count", n_wr, 3);
      check("full_cyc0", wr_cyc[0], 2);
      check("full_cyc1", wr_cyc[1], 8);
      check("full_cyc2", wr_cyc[2], 9);
      check("full_held_grant", {31'h0, act_log[7]}, 1);
      check("full_released", {31'h0, act_log[10]}, 0);

      // Idle timeout: requester 1 goes quiet after one beat; requester 3 waits.
      do_reset();
      load(1, 8'h51, 1'b0);
      for (int s = 1; s <= 14; s++) begin
         if (s == 3) load(3, 8'hA3, 1'b1);
         step(1'b0);
      end
      check("to_count", n_wr, 2);
      check("to_first_gid", {30'h0, wr_gid[0]}, 1);
      check("to_last_idle_cycle", {31'h0, act_log[10]}, 1);
      check("to_release", {31'h0, act_log[11]}, 0);
      check("to_next_cycle", wr_cyc[1], 12);
      check("to_next_gid", {30'h0, wr_gid[1]}, 3);

      // Same, but full during three idle cycles must not count toward timeout.
      do_reset();
      load(1, 8'h52, 1'b0);
      for (int s = 1; s <= 18; s++) begin
         if (s == 3) load(3, 8'hA3, 1'b1);
         step(s >= 4 && s <= 6);
      end
      check("tof_count", n_wr, 2);
      check("tof_last_idle_cycle", {31'h0, act_log[13]}, 1);
      check("tof_release", {31'h0, act_log[14]}, 0);
      check("tof_next_cycle", wr_cyc[1], 15);
      check("tof_next_gid", {30'h0, wr_gid[1]}, 3);

      // Asynchronous reset in the middle of a burst.
      do_reset();
      load(0, 8'h61, 1'b0);
      load(0, 8'h62, 1'b0);
      load(0, 8'h63, 1'b1);
      step(1'b0);
      step(1'b0);
      check("mid_wr_en_before", {31'h0, fifo_wr_en}, 1);
      #1 wr_rst = 1'b1;
      #1;
      check("mid_wr_en_async", {31'h0, fifo_wr_en}, 0);
      check("mid_outputs_async", {16'h0, fifo_wr_en, req_ready, grant_active, grant_id, fifo_wr_data}, 32'h0);
      do_reset();

      check("no_write_while_full", inv_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
